// File: rtl/dc_ipu_filter_pkg.sv
// Shared definitions for the IPU filter datapath: window dimension and window FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dc_ipu_filter_pkg;

    localparam int MATRIX_DIM = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } win_state_e;

endpackage

// File: rtl/dc_ipu_texel_window_oreg.sv
// Output holding register for the texel window: valid flag plus texel and weight matrices.
// Latency: 1 cycle from load to out_valid.
// Backpressure: valid and data hold while out_valid && !out_ready; the caller only loads when the slot is free or draining.
// Ports: clk/clr (sync active-high), load + load_texel/load_weights in, out_ready in,
//        out_valid/texel_matrix/weights_matrix out.
module dc_ipu_texel_window_oreg
    import dc_ipu_filter_pkg::*;
#(
    parameter int COLOR_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           load,
    input  logic [COLOR_WIDTH-1:0]         load_texel     [0:MATRIX_DIM-1][0:MATRIX_DIM-1],
    input  logic signed [WEIGHT_WIDTH-1:0] load_weights   [0:MATRIX_DIM-1][0:MATRIX_DIM-1],
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [COLOR_WIDTH-1:0]         texel_matrix   [0:MATRIX_DIM-1][0:MATRIX_DIM-1],
    output logic signed [WEIGHT_WIDTH-1:0] weights_matrix [0:MATRIX_DIM-1][0:MATRIX_DIM-1]
);

    logic                           valid_q, valid_d;
    logic [COLOR_WIDTH-1:0]         texel_q   [0:MATRIX_DIM-1][0:MATRIX_DIM-1];
    logic [COLOR_WIDTH-1:0]         texel_d   [0:MATRIX_DIM-1][0:MATRIX_DIM-1];
    logic signed [WEIGHT_WIDTH-1:0] weights_q [0:MATRIX_DIM-1][0:MATRIX_DIM-1];
    logic signed [WEIGHT_WIDTH-1:0] weights_d [0:MATRIX_DIM-1][0:MATRIX_DIM-1];

    always_comb begin
        // A load always wins over a drain, giving back-to-back windows without a bubble.
        valid_d   = valid_q && !out_ready;
        texel_d   = texel_q;
        weights_d = weights_q;
        if (load) begin
            valid_d   = 1'b1;
            texel_d   = load_texel;
            weights_d = load_weights;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q   <= 1'b0;
            texel_q   <= '{default: '0};
            weights_q <= '{default: '0};
        end else begin
            valid_q   <= valid_d;
            texel_q   <= texel_d;
            weights_q <= weights_d;
        end
    end

    assign out_valid      = valid_q;
    assign texel_matrix   = texel_q;
    assign weights_matrix = weights_q;

endmodule

// File: rtl/dc_ipu_texel_window.sv
// Sliding 4x4 texel window builder: shifts in one vertical column per beat and emits the window plus its weights.
// Latency: 1 cycle from accepted beat to out_valid.
// Backpressure: in_ready = clr || !out_valid || out_ready; a stalled window holds and stalls the input.
// Ports: clk, clr (sync active-high), in_valid/in_ready/in_sol/in_column/in_weights,
//        out_valid/out_ready/texel_matrix/weights_matrix, err_no_sol (sticky until clr).
// Build option: DC_IPU_TEXEL_WINDOW_EDGE_CLAMP_EN replicates the first column of a line across the whole window.
module dc_ipu_texel_window
    import dc_ipu_filter_pkg::*;
#(
    parameter int COLOR_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sol,
    input  logic [COLOR_WIDTH-1:0]         in_column      [0:MATRIX_DIM-1],
    input  logic signed [WEIGHT_WIDTH-1:0] in_weights     [0:MATRIX_DIM-1][0:MATRIX_DIM-1],
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [COLOR_WIDTH-1:0]         texel_matrix   [0:MATRIX_DIM-1][0:MATRIX_DIM-1],
    output logic signed [WEIGHT_WIDTH-1:0] weights_matrix [0:MATRIX_DIM-1][0:MATRIX_DIM-1],
    output logic                           err_no_sol
);

`ifdef DC_IPU_TEXEL_WINDOW_EDGE_CLAMP_EN
    localparam bit EDGE_CLAMP = 1'b1;
`else
    localparam bit EDGE_CLAMP = 1'b0;
`endif

    win_state_e             state_q, state_d;
    logic                   err_no_sol_q, err_no_sol_d;
    logic                   beat_acc;
    logic                   load;
    logic [COLOR_WIDTH-1:0] win_nxt [0:MATRIX_DIM-1][0:MATRIX_DIM-1];

    // clr forces ready so an upstream beat presented during clr is consumed and dropped.
    assign in_ready = clr || !out_valid || out_ready;
    assign beat_acc = in_valid && in_ready && !clr;

    // The output register doubles as the window store: shifting reads the last loaded window.
    always_comb begin
        state_d      = state_q;
        err_no_sol_d = err_no_sol_q;
        load         = 1'b0;
        win_nxt      = texel_matrix;
        if (beat_acc) begin
            if (in_sol) begin
                state_d = RUN;
                load    = 1'b1;
                for (int r = 0; r < MATRIX_DIM; r++) begin
                    for (int c = 0; c < MATRIX_DIM - 1; c++) begin
                        win_nxt[r][c] = EDGE_CLAMP ? in_column[r] : '0;
                    end
                    win_nxt[r][MATRIX_DIM-1] = in_column[r];
                end
            end else if (state_q == RUN) begin
                load = 1'b1;
                for (int r = 0; r < MATRIX_DIM; r++) begin
                    for (int c = 0; c < MATRIX_DIM - 1; c++) begin
                        win_nxt[r][c] = texel_matrix[r][c+1];
                    end
                    win_nxt[r][MATRIX_DIM-1] = in_column[r];
                end
            end else begin
                // Column arrived with no open line: drop it and flag.
                err_no_sol_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            err_no_sol_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_no_sol_q <= err_no_sol_d;
        end
    end

    assign err_no_sol = err_no_sol_q;

    dc_ipu_texel_window_oreg #(
        .COLOR_WIDTH  (COLOR_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_oreg (
        .clk            (clk),
        .clr            (clr),
        .load           (load),
        .load_texel     (win_nxt),
        .load_weights   (in_weights),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .texel_matrix   (texel_matrix),
        .weights_matrix (weights_matrix)
    );

endmodule

// File: tb/tb_dc_ipu_texel_window.sv
// Self-checking bench for dc_ipu_texel_window: scoreboard of expected windows plus per-scenario checks.
// Latency: expects out_valid one cycle after an accepted beat.
// Backpressure: exercises output stalls and reset while a window is pending.
module tb_dc_ipu_texel_window;

    localparam int CW = 8;
    localparam int WW = 16;

`ifdef DC_IPU_TEXEL_WINDOW_EDGE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0][3:0][CW-1:0] tex;
        logic [3:0][3:0][WW-1:0] w;
    } win_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic in_valid = 1'b0;
    logic in_sol = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, err_no_sol;
    logic [CW-1:0]         in_column      [0:3];
    logic signed [WW-1:0]  in_weights     [0:3][0:3];
    logic [CW-1:0]         texel_matrix   [0:3][0:3];
    logic signed [WW-1:0]  weights_matrix [0:3][0:3];

    int   n_cmp = 0;
    int   n_bad = 0;
    win_t sb_q[$];
    win_t m_win = '0;
    bit   m_run = 1'b0;
    bit   m_err = 1'b0;
    int   beat_no = 0;
    int   n_out = 0;

    always #5 clk = ~clk;

    dc_ipu_texel_window #(
        .COLOR_WIDTH  (CW),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sol         (in_sol),
        .in_column      (in_column),
        .in_weights     (in_weights),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .texel_matrix   (texel_matrix),
        .weights_matrix (weights_matrix),
        .err_no_sol     (err_no_sol)
    );

    // Present a beat; column rows are base+row, weights are 16*beat+4r+c.
    task automatic put_beat(input bit sol, input logic [CW-1:0] base, output int b);
        b = beat_no;
        beat_no++;
        in_valid = 1'b1;
        in_sol   = sol;
        for (int r = 0; r < 4; r++) begin
            in_column[r] = base + CW'(r);
            for (int c = 0; c < 4; c++) in_weights[r][c] = WW'(16 * b + 4 * r + c);
        end
    endtask

    // One clock: sample outputs mid-cycle against the model, advance the model, step past the edge.
    task automatic tick();
        bit   exp_vld, exp_rdy, in_acc;
        int   bt, bw;
        win_t nw;
        string where;
        #1;
        exp_vld = (sb_q.size() != 0);
        exp_rdy = clr || !exp_vld || out_ready;
        n_cmp++;
        if (out_valid !== exp_vld) begin
            n_bad++;
            $display("FAIL sb_out_valid t=%0t: got %b want %b", $time, out_valid, exp_vld);
        end
        n_cmp++;
        if (in_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL sb_in_ready t=%0t: got %b want %b", $time, in_ready, exp_rdy);
        end
        n_cmp++;
        if (err_no_sol !== m_err) begin
            n_bad++;
            $display("FAIL sb_err_no_sol t=%0t: got %b want %b", $time, err_no_sol, m_err);
        end
        if (exp_vld) begin
            bt = 0;
            bw = 0;
            where = "";
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (texel_matrix[r][c] !== sb_q[0].tex[r][c]) begin
                        if (bt == 0) where = $sformatf("tex[%0d][%0d] got %h want %h", r, c,
                                                       texel_matrix[r][c], sb_q[0].tex[r][c]);
                        bt++;
                    end
                    if (weights_matrix[r][c] !== sb_q[0].w[r][c]) begin
                        if (bw == 0 && bt == 0) where = $sformatf("w[%0d][%0d] got %h want %h", r, c,
                                                                  weights_matrix[r][c], sb_q[0].w[r][c]);
                        bw++;
                    end
                end
            end
            n_cmp++;
            if (bt + bw != 0) begin
                n_bad++;
                $display("FAIL sb_window t=%0t: %0d texel and %0d weight entries differ, first %s",
                         $time, bt, bw, where);
            end
        end
        in_acc = in_valid && exp_rdy && !clr;
        if (exp_vld && out_ready) begin
            void'(sb_q.pop_front());
            n_out++;
        end
        if (clr) begin
            sb_q.delete();
            m_win = '0;
            m_run = 1'b0;
            m_err = 1'b0;
        end else if (in_acc) begin
            if (in_sol || m_run) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        if (c == 3)
                            nw.tex[r][c] = in_column[r];
                        else if (in_sol)
                            nw.tex[r][c] = CLAMP ? in_column[r] : '0;
                        else
                            nw.tex[r][c] = m_win.tex[r][c+1];
                        nw.w[r][c] = in_weights[r][c];
                    end
                end
                m_run = 1'b1;
                m_win = nw;
                sb_q.push_back(nw);
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        int b;
        put_beat(1'b1, 8'hEE, b);   // presented during clr, must be ignored
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || err_no_sol !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ctrl: got vld=%b err=%b rdy=%b want 0 0 1", out_valid, err_no_sol, in_ready);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                n_cmp++;
                if (texel_matrix[r][c] !== '0 || weights_matrix[r][c] !== '0) begin
                    n_bad++;
                    $display("FAIL reset_data[%0d][%0d]: got tex=%h w=%h want 0", r, c,
                             texel_matrix[r][c], weights_matrix[r][c]);
                end
            end
        end
    endtask

    task automatic test_sol_load();
        int b;
        logic [CW-1:0] e;
        do_clr();
        out_ready = 1'b0;
        put_beat(1'b1, 8'd1, b);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL sol_load_valid: got %b want 1", out_valid);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                e = (c == 3 || CLAMP) ? CW'(r + 1) : '0;
                n_cmp++;
                if (texel_matrix[r][c] !== e) begin
                    n_bad++;
                    $display("FAIL sol_load_tex[%0d][%0d]: got %h want %h", r, c, texel_matrix[r][c], e);
                end
            end
        end
        tick();
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_shift();
        int b, start;
        logic [CW-1:0] e;
        do_clr();
        out_ready = 1'b1;
        start = n_out;
        put_beat(1'b1, 8'h10, b);
        tick();
        put_beat(1'b0, 8'h20, b);
        tick();
        put_beat(1'b0, 8'h30, b);
        tick();
        put_beat(1'b0, 8'h40, b);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                e = CW'(16 * (c + 1) + r);
                n_cmp++;
                if (texel_matrix[r][c] !== e) begin
                    n_bad++;
                    $display("FAIL shift_abcd[%0d][%0d]: got %h want %h", r, c, texel_matrix[r][c], e);
                end
            end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (n_out - start != 4) begin
            n_bad++;
            $display("FAIL shift_count: got %0d windows want 4", n_out - start);
        end
    endtask

    task automatic test_back_to_back();
        int b, start;
        do_clr();
        out_ready = 1'b0;
        start = n_out;
        put_beat(1'b1, 8'h50, b);
        tick();
        put_beat(1'b0, 8'h60, b);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_%0d: got rdy=%b vld=%b want 0 1", i, in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL no_bubble_%0d: got vld=%b want 1", i, out_valid);
            end
            if (i < 3) begin
                put_beat(1'b0, CW'(8'h70 + 16 * i), b);
                tick();
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || n_out - start != 5) begin
            n_bad++;
            $display("FAIL drain: got vld=%b windows=%0d want 0 5", out_valid, n_out - start);
        end
    endtask

    task automatic test_no_sol();
        int b;
        do_clr();
        out_ready = 1'b1;
        put_beat(1'b0, 8'hA0, b);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || err_no_sol !== 1'b1) begin
            n_bad++;
            $display("FAIL no_sol: got vld=%b err=%b want 0 1", out_valid, err_no_sol);
        end
        put_beat(1'b1, 8'hB0, b);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (err_no_sol !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 1", err_no_sol);
        end
        do_clr();
        n_cmp++;
        if (err_no_sol !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clr: got %b want 0", err_no_sol);
        end
    endtask

    task automatic test_clr_midline();
        int b;
        do_clr();
        out_ready = 1'b1;
        put_beat(1'b1, 8'hC0, b);
        tick();
        put_beat(1'b0, 8'hD0, b);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_mid_ctrl: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                n_cmp++;
                if (texel_matrix[r][c] !== '0 || weights_matrix[r][c] !== '0) begin
                    n_bad++;
                    $display("FAIL clr_mid_data[%0d][%0d]: got tex=%h w=%h want 0", r, c,
                             texel_matrix[r][c], weights_matrix[r][c]);
                end
            end
        end
        out_ready = 1'b1;
        put_beat(1'b0, 8'hE0, b);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (err_no_sol !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_mid_idle: got err=%b vld=%b want 1 0", err_no_sol, out_valid);
        end
    endtask

    task automatic test_weights();
        int b;
        logic signed [WW-1:0] e;
        do_clr();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            put_beat(k == 0, CW'(8'h11 * k), b);
            tick();
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    e = WW'(16 * b + 4 * r + c);
                    n_cmp++;
                    if (weights_matrix[r][c] !== e) begin
                        n_bad++;
                        $display("FAIL weights_b%0d[%0d][%0d]: got %h want %h", b, r, c,
                                 weights_matrix[r][c], e);
                    end
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        for (int r = 0; r < 4; r++) begin
            in_column[r] = '0;
            for (int c = 0; c < 4; c++) in_weights[r][c] = '0;
        end
        test_reset();
        test_sol_load();
        test_shift();
        test_back_to_back();
        test_no_sol();
        test_clr_midline();
        test_weights();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dc_ipu_texel_window.md
DC_IPU_TEXEL_WINDOW -- requirements
Module: dc_ipu_texel_window

Interface
REQ-001 SHALL have parameter COLOR_WIDTH, default 8: bit width of one texel colour component.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 16: bit width of one signed filter weight.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port clr, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: column beat valid.
REQ-006 SHALL have port in_ready, output, 1: column beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_sol, input, 1: beat is the first column of a line.
REQ-008 SHALL have port in_column[0:3], input, COLOR_WIDTH each: one vertical 4-texel column; index = row.
REQ-009 SHALL have port in_weights[0:3][0:3], input, signed WEIGHT_WIDTH each: weights for the window completed by this beat.
REQ-010 SHALL have port out_valid, output, 1: window valid.
REQ-011 SHALL have port out_ready, input, 1: downstream filter core accepts the window.
REQ-012 SHALL have port texel_matrix[0:3][0:3], output, COLOR_WIDTH each: [row][col], col 3 = newest column.
REQ-013 SHALL have port weights_matrix[0:3][0:3], output, signed WEIGHT_WIDTH each: registered copy of in_weights.
REQ-014 SHALL have port err_no_sol, output, 1: sticky flag, beat received outside a line.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; IDLE after reset.
REQ-016 SHALL hold in_ready = !out_valid || out_ready in both states.
REQ-017 SHALL, on an accepted beat with in_sol=1 in either state, enter RUN, load the window per REQ-027/REQ-028, and present it as the output.
REQ-018 SHALL, on an accepted beat with in_sol=0 in RUN, shift the window: col0<=col1, col1<=col2, col2<=col3, col3<=in_column.
REQ-019 SHALL, on an accepted beat with in_sol=0 in IDLE, discard the beat, produce no output, and set err_no_sol.
REQ-020 SHALL produce exactly one output window per accepted RUN/sol beat, with 1-cycle latency: out_valid rises on the cycle after acceptance.
REQ-021 SHALL register in_weights into weights_matrix on the same beat as the texel update.
REQ-022 SHALL keep out_valid and all output data stable while out_valid && !out_ready.
REQ-023 SHALL, when out_valid && out_ready coincide with a new accepted beat, load the new window with no bubble, sustaining 1 window/cycle.
REQ-024 SHALL, when out_valid && out_ready occur with no new beat, drop out_valid on the next cycle.
REQ-025 SHALL treat a sol beat received in RUN as a restart of the line; the previous window content is lost.

Reset
REQ-026 SHALL, while clr=1: enter IDLE, set out_valid=0, err_no_sol=0, all texel_matrix and weights_matrix entries =0, and in_ready=1; a beat presented during clr SHALL be ignored, and clr mid-line SHALL abort the line.

Configuration
REQ-027 SHALL, with DC_IPU_TEXEL_WINDOW_EDGE_CLAMP_EN defined, load in_column into all four window columns on a sol beat (left-edge clamp).
REQ-028 SHALL, without DC_IPU_TEXEL_WINDOW_EDGE_CLAMP_EN, load col3=in_column and col0..col2=0 on a sol beat.

Structure
REQ-029 SHALL take MATRIX_DIM=4 and the FSM state enum from shared package dc_ipu_filter_pkg.
REQ-030 SHALL place the output valid/data holding register in sub-module dc_ipu_texel_window_oreg; the FSM and shift logic SHALL reside in the top module.

Verification
REQ-031 Bench SHALL cover: sol beat with column {1,2,3,4}, clamp on -> next cycle out_valid=1 and every texel_matrix column = {1,2,3,4}; with clamp off -> col3={1,2,3,4}, col0..col2=0.
REQ-032 Bench SHALL cover: sol beat then 3 beats with columns A,B,C,D, out_ready=1 -> 4 windows; the last has col0..3 = A,B,C,D (clamp on).
REQ-033 Bench SHALL cover: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, output stable; then out_ready=1 -> one window per cycle with no bubble.
REQ-034 Bench SHALL cover: after reset, beat with in_sol=0 -> no out_valid and err_no_sol=1; err_no_sol stays 1 after a later sol beat until clr.
REQ-035 Bench SHALL cover: clr asserted for 1 cycle while out_valid=1 mid-line -> next cycle out_valid=0, outputs 0, state IDLE; the following in_sol=0 beat sets err_no_sol.
REQ-036 Bench SHALL cover: weights distinct on each beat (e.g. w[r][c]=16*beat+4r+c) -> each output weights_matrix matches the beat that produced its window.
